// File: rtl/unified_mem_port.sv
// unified_mem_port: one single-port word RAM shared by an instruction-fetch
// port and a data load/store port. Requests are serialized through an
// IDLE -> ACCESS -> RESPOND sequence with alternating-priority arbitration.
module unified_mem_port #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req_valid,
   input  logic [31:0] if_req_addr,
   output logic        if_req_ready,
   output logic        if_rsp_valid,
   output logic [31:0] if_rsp_data,
   input  logic        d_req_valid,
   input  logic        d_req_we,
   input  logic [1:0]  d_req_size,
   input  logic        d_req_unsigned,
   input  logic [31:0] d_req_addr,
   input  logic [31:0] d_req_wdata,
   output logic        d_req_ready,
   output logic        d_rsp_valid,
   output logic [31:0] d_rsp_data,
   output logic        d_misaligned,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [2:0] LAT3 = 3'(LATENCY);

   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        last_fetch_q, last_fetch_d;
   logic        is_data_q, we_q, uns_q;
   logic [1:0]  size_q;
   logic [AW+1:0] addr_q;
   logic [31:0] wdata_q, rdata_q;
   logic [31:0] mem [DEPTH];

   logic        sel_data, accept, commit, mis;
   logic [3:0]  be;
   logic [31:0] wsh, lsh, ld;
   logic [AW-1:0] idx;

   // Address bits above the RAM window only wrap, so they are never looked at.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_req_addr[31:AW+2], d_req_addr[31:AW+2]};

   assign idx = addr_q[AW+1:2];

   // Arbitration and handshake: data wins a conflict unless it won last time.
   always_comb begin
      sel_data     = d_req_valid && (!if_req_valid || last_fetch_q);
      if_req_ready = (state_q == IDLE) && !reset && !sel_data;
      d_req_ready  = (state_q == IDLE) && !reset && sel_data;
      accept       = (if_req_valid && if_req_ready) || (d_req_valid && d_req_ready);
   end

   // Next-state logic; ACCESS lasts exactly LATENCY cycles.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_fetch_d = last_fetch_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d      = ACCESS;
            cnt_d        = LAT3;
            last_fetch_d = !sel_data;
         end
         ACCESS: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
               state_d = RESPOND;
               cnt_d   = 3'd0;
            end
         end
         RESPOND: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign commit = (state_q == ACCESS) && (cnt_q <= 3'd1);

   // State, counter and last-grant registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 3'd0;
         last_fetch_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_fetch_q <= last_fetch_d;
      end
   end

   // Capture the granted request; a fetch looks like an aligned word load.
   always_ff @(posedge clk) begin
      if (reset) begin
         is_data_q <= 1'b0;
         we_q      <= 1'b0;
         uns_q     <= 1'b0;
         size_q    <= 2'b10;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else if (accept) begin
         is_data_q <= sel_data;
         we_q      <= sel_data && d_req_we;
         uns_q     <= sel_data && d_req_unsigned;
         size_q    <= sel_data ? d_req_size : 2'b10;
         addr_q    <= sel_data ? d_req_addr[AW+1:0] : if_req_addr[AW+1:0];
         wdata_q   <= sel_data ? d_req_wdata : 32'd0;
      end
   end

   // Misalignment check and store lane enables / replicated store data.
   always_comb begin
      mis = is_data_q && (((size_q == 2'b01) && addr_q[0]) ||
                          (size_q[1] && (addr_q[1:0] != 2'b00)));
      case (size_q)
         2'b00: begin
            be  = 4'b0001 << addr_q[1:0];
            wsh = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be  = addr_q[1] ? 4'b1100 : 4'b0011;
            wsh = {2{wdata_q[15:0]}};
         end
         default: begin
            be  = 4'b1111;
            wsh = wdata_q;
         end
      endcase
   end

   // RAM write on the ACCESS->RESPOND edge; contents survive reset.
   always_ff @(posedge clk) begin
      if (!reset && commit && is_data_q && we_q && !mis) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
         end
      end
   end

   // RAM read sampled on the same edge as the write.
   always_ff @(posedge clk) begin
      if (reset) rdata_q <= '0;
      else if (commit) rdata_q <= mem[idx];
   end

   // Load alignment and extension.
   always_comb begin
      lsh = rdata_q >> {addr_q[1:0], 3'b000};
      case (size_q)
         2'b00:   ld = uns_q ? {24'd0, lsh[7:0]} : {{24{lsh[7]}}, lsh[7:0]};
         2'b01:   ld = uns_q ? {16'd0, lsh[15:0]} : {{16{lsh[15]}}, lsh[15:0]};
         default: ld = rdata_q;
      endcase
   end

   // Response outputs, zero whenever not valid.
   always_comb begin
      busy         = (state_q != IDLE) && !reset;
      if_rsp_valid = (state_q == RESPOND) && !reset && !is_data_q;
      d_rsp_valid  = (state_q == RESPOND) && !reset && is_data_q;
      if_rsp_data  = if_rsp_valid ? rdata_q : 32'd0;
      d_rsp_data   = (d_rsp_valid && !we_q && !mis) ? ld : 32'd0;
      d_misaligned = d_rsp_valid && mis;
   end

endmodule

// File: tb/tb_unified_mem_port.sv
// Randomized scoreboard bench for unified_mem_port against a byte-array model.
module tb_unified_mem_port;

   localparam int DEPTH = 64;
   localparam int LAT   = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req_valid, if_req_ready, if_rsp_valid;
   logic [31:0] if_req_addr, if_rsp_data;
   logic        d_req_valid, d_req_we, d_req_unsigned, d_req_ready;
   logic [1:0]  d_req_size;
   logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
   logic        d_rsp_valid, d_misaligned, busy;

   unified_mem_port #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
      .if_req_ready(if_req_ready), .if_rsp_valid(if_rsp_valid),
      .if_rsp_data(if_rsp_data),
      .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_size(d_req_size),
      .d_req_unsigned(d_req_unsigned), .d_req_addr(d_req_addr),
      .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
      .d_misaligned(d_misaligned), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_data;
      logic [31:0] data;
      bit          mis;
      int          acc;
   } exp_t;

   exp_t q[$];
   int n_chk = 0;
   int n_pass = 0;
   byte unsigned mbytes [4*DEPTH];
   bit model_last_fetch = 1'b1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic fail(input string name);
      n_chk++;
      $display("FAIL %s", name);
   endtask

   // Byte-addressed reference memory with wrap, alignment and extension rules.
   function automatic void model(input bit is_data, input bit we, input logic [1:0] size,
                                 input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] data, output bit mis);
      int a, n;
      logic [31:0] v;
      a = int'(addr % (4*DEPTH));
      n = (!is_data || size[1]) ? 4 : ((size == 2'b01) ? 2 : 1);
      if (!is_data) a = a - (a % 4);
      mis  = (a % n) != 0;
      data = 32'd0;
      if (!mis) begin
         if (is_data && we) begin
            for (int i = 0; i < n; i++) mbytes[a+i] = 8'(wdata >> (8*i));
         end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(mbytes[a+i]) << (8*i));
            if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            data = v;
         end
      end
   endfunction

   task automatic push(input bit is_data, input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int acc);
      exp_t e;
      e.is_data = is_data;
      e.acc = acc;
      model(is_data, we, size, uns, addr, wdata, e.data, e.mis);
      q.push_back(e);
      model_last_fetch = !is_data;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && q.size() != 0; k++) begin
         @(negedge clk); #2;
      end
      if (q.size() != 0) begin
         fail("response_timeout");
         q.delete();
      end
   endtask

   task automatic set_d(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      d_req_we = we; d_req_size = size; d_req_unsigned = uns;
      d_req_addr = addr; d_req_wdata = wdata;
   endtask

   // Wait (bounded) for the given channel's ready; returns 1 if seen.
   task automatic wait_ready(input bit is_data, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (is_data ? d_req_ready : if_req_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      if (!ok) fail(is_data ? "d_ready_timeout" : "if_ready_timeout");
   endtask

   // One request on one channel, then wait for its response.
   task automatic req(input bit is_data, input bit we, input logic [1:0] size, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
      bit ok;
      if (is_data) begin set_d(we, size, uns, addr, wdata); d_req_valid = 1'b1; end
      else begin if_req_addr = addr; if_req_valid = 1'b1; end
      #1;
      wait_ready(is_data, ok);
      if (ok) push(is_data, we, size, uns, addr, wdata, cyc + 1);
      @(posedge clk); #1;
      d_req_valid = 1'b0; if_req_valid = 1'b0;
      drain();
   endtask

   // Both channels request together; the model predicts who goes first.
   task automatic both(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] daddr, input logic [31:0] wdata, input logic [31:0] faddr);
      bit ok, win_d;
      @(negedge clk); #1;
      set_d(we, size, uns, daddr, wdata);
      if_req_addr = faddr;
      d_req_valid = 1'b1; if_req_valid = 1'b1;
      #1;
      win_d = model_last_fetch;
      check("arb_d_ready", d_req_ready, win_d);
      check("arb_if_ready", if_req_ready, !win_d);
      if (win_d) push(1'b1, we, size, uns, daddr, wdata, cyc + 1);
      else       push(1'b0, 1'b0, 2'b10, 1'b0, faddr, 32'd0, cyc + 1);
      @(posedge clk); #1;
      if (win_d) d_req_valid = 1'b0; else if_req_valid = 1'b0;
      wait_ready(!win_d, ok);
      if (ok) begin
         if (win_d) push(1'b0, 1'b0, 2'b10, 1'b0, faddr, 32'd0, cyc + 1);
         else       push(1'b1, we, size, uns, daddr, wdata, cyc + 1);
      end
      @(posedge clk); #1;
      d_req_valid = 1'b0; if_req_valid = 1'b0;
      drain();
   endtask

   // Monitor: pop and compare on every response pulse, and check idle outputs stay 0.
   always @(negedge clk) begin
      exp_t e;
      if (reset !== 1'b1) begin
         if (if_rsp_valid && d_rsp_valid) fail("two_responses");
         else if (if_rsp_valid || d_rsp_valid) begin
            if (q.size() == 0) fail("unexpected_rsp");
            else begin
               e = q.pop_front();
               check("rsp_kind", {31'd0, d_rsp_valid}, {31'd0, e.is_data});
               check("rsp_data", e.is_data ? d_rsp_data : if_rsp_data, e.data);
               if (e.is_data) check("rsp_misaligned", {31'd0, d_misaligned}, {31'd0, e.mis});
               check("rsp_latency", 32'(cyc + 1 - e.acc), 32'(LAT + 1));
            end
         end else begin
            check("idle_rsp_zero", if_rsp_data | d_rsp_data | {31'd0, d_misaligned}, 32'd0);
         end
      end
   end

   initial begin
      int op;
      logic [31:0] a;
      bit ok;
      reset = 1'b1;
      if_req_valid = 1'b0; if_req_addr = '0;
      d_req_valid = 1'b0; set_d(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      foreach (mbytes[i]) mbytes[i] = 8'd0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      if_req_valid = 1'b1; d_req_valid = 1'b1; #1;
      check("reset_readies", {30'd0, if_req_ready, d_req_ready}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_rsp", {30'd0, if_rsp_valid, d_rsp_valid}, 32'd0);
      if_req_valid = 1'b0; d_req_valid = 1'b0;
      @(negedge clk); reset = 1'b0; #1;
      check("ready_after_reset", {31'd0, if_req_ready | d_req_ready}, 32'd1);

      // First conflict after reset: data first, then fetch.
      both(1'b1, 2'b10, 1'b0, 32'h4, 32'h0BAD_F00D, 32'h4);

      // Initialize every RAM word.
      for (int i = 0; i < DEPTH; i++) req(1'b1, 1'b1, 2'b10, 1'b0, 32'(4*i), $urandom);

      // Directed lane/extension cases.
      req(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
      req(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
      req(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
      req(1'b1, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234);
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      req(1'b1, 1'b1, 2'b10, 1'b0, 32'h11, 32'h5555_5555);
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      req(1'b1, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
      req(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'hA5A5_A5A5);
      req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
      req(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);

      // Randomized traffic with occasional conflicts and wrapping addresses.
      for (int n = 0; n < 200; n++) begin
         op = $urandom_range(0, 8);
         a = $urandom_range(0, 4*DEPTH - 1);
         if ($urandom_range(0, 3) == 0) a = a | ($urandom << 8);
         if (op <= 3)      req(1'b1, 1'b0, 2'($urandom), 1'($urandom), a, 32'h0);
         else if (op <= 6) req(1'b1, 1'b1, 2'($urandom), 1'b0, a, $urandom);
         else if (op == 7) req(1'b0, 1'b0, 2'b10, 1'b0, a, 32'h0);
         else both(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                   32'($urandom_range(0, 4*DEPTH - 1)));
      end

      // Reset during the ACCESS phase of a store: no write, no response.
      req(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
      @(negedge clk); #1;
      set_d(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D);
      d_req_valid = 1'b1; #1;
      wait_ready(1'b1, ok);
      @(posedge clk); #1;
      d_req_valid = 1'b0;
      @(negedge clk); reset = 1'b1; #1;
      check("midreset_busy", {31'd0, busy}, 32'd0);
      check("midreset_rsp", {30'd0, if_rsp_valid, d_rsp_valid}, 32'd0);
      @(negedge clk); reset = 1'b0; model_last_fetch = 1'b1; #1;
      check("ready_after_midreset", {31'd0, if_req_ready | d_req_ready}, 32'd1);
      check("idle_after_midreset", {31'd0, busy}, 32'd0);
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

      repeat (3) @(negedge clk);
      if (q.size() != 0) fail("leftover_expected");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/unified_mem_port.md
UNIFIED_MEM_PORT -- requirements
Module: unified_mem_port

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words; power of 2.
REQ-002 SHALL have parameter LATENCY, default 1, meaning wait cycles per access; legal range 1..7.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port if_req_valid  input  1  instruction-fetch request.
REQ-006 SHALL have port if_req_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-007 SHALL have port if_req_ready  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port if_rsp_valid  output  1  one-cycle fetch response pulse.
REQ-009 SHALL have port if_rsp_data  output  32  fetched instruction word.
REQ-010 SHALL have port d_req_valid  input  1  data request.
REQ-011 SHALL have port d_req_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port d_req_size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-013 SHALL have port d_req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-014 SHALL have port d_req_addr  input  32  data byte address.
REQ-015 SHALL have port d_req_wdata  input  32  store data, right-aligned.
REQ-016 SHALL have port d_req_ready  output  1  data request accepted this cycle.
REQ-017 SHALL have port d_rsp_valid  output  1  one-cycle data response pulse; loads and stores.
REQ-018 SHALL have port d_rsp_data  output  32  extended load data; 0 for stores and errors.
REQ-019 SHALL have port d_misaligned  output  1  qualifies d_rsp_valid; access rejected.
REQ-020 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-021 SHALL implement FSM IDLE -> ACCESS -> RESPOND -> IDLE over a single-port word RAM indexed by addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH.
REQ-022 SHALL assert if_req_ready/d_req_ready combinationally only in IDLE and only toward the granted requester; a request is accepted when valid && ready at a rising edge, and all request fields are latched at that edge.
REQ-023 SHALL arbitrate when both requesters are valid in IDLE by granting the requester not granted last; a last-grant flag resets to "fetch", so data wins the first conflict.
REQ-024 SHALL remain in ACCESS for exactly LATENCY cycles, counted by a 3-bit counter loaded at acceptance.
REQ-025 SHALL commit stores and sample RAM reads on the ACCESS->RESPOND edge, so the response is high exactly LATENCY+1 edges after the acceptance edge, for one cycle.
REQ-026 SHALL update byte lanes little-endian on stores: byte writes lane addr[1:0] with wdata[7:0]; half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; word writes all lanes; other lanes are unchanged.
REQ-027 SHALL align loads to the addressed lane and extend to 32 bits according to d_req_unsigned.
REQ-028 SHALL flag as misaligned any half access with addr[0]=1 and any word access with addr[1:0]!=0: no RAM write, d_rsp_data=0, d_misaligned=1 with d_rsp_valid, same timing as a normal access.
REQ-029 SHALL hold rsp data outputs at 0 when the corresponding rsp_valid is low.
REQ-030 SHALL serialize accesses, so a load accepted after a store completes returns the stored value.
REQ-031 SHALL ignore requests arriving outside IDLE; the requester holds valid until ready.

Reset
REQ-032 SHALL, while reset is high at an edge, force IDLE, counter 0, last-grant to "fetch", and all outputs to 0 (readies 0 during reset).
REQ-033 SHALL discard an access in progress when reset asserts mid-operation, performing no RAM write and producing no response; RAM contents are not cleared.
REQ-034 SHALL present ready in IDLE on the first cycle after reset deasserts.

Verification
REQ-035 SHALL be verified by: word store 0xDEADBEEF @0x10, then byte load @0x13 signed -> 0xFFFFFFDE, and unsigned -> 0x000000DE.
REQ-036 SHALL be verified by: after REQ-035, half store 0x1234 @0x12, then word load @0x10 -> 0x1234BEEF.
REQ-037 SHALL be verified by: after reset, if_req_valid and d_req_valid raised in the same cycle -> data granted first, fetch granted next; with LATENCY=1, each rsp_valid is seen 2 edges after its acceptance.
REQ-038 SHALL be verified by: word store @0x11 -> d_misaligned=1 and d_rsp_data=0, and a word load @0x10 is unchanged.
REQ-039 SHALL be verified by: reset asserted during ACCESS of a store to 0x20 -> no response, word @0x20 unchanged, ready high the cycle after reset deasserts.
REQ-040 SHALL be verified by: with DEPTH=64, word store 0xA5A5A5A5 @0x100 -> fetch @0x0 returns 0xA5A5A5A5.
